// File: rtl/fm_mod_pkg.sv
// Shared types and constants for the FM phase-increment generator and the NCO it feeds.
package fm_mod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2,
        RAMP = 2'd3
    } fm_state_t;

    localparam logic [31:0] FM_DEF_CARRIER_FCW = 32'h0400_0000;
    localparam logic [31:0] FM_DEF_MAX_DEV     = 32'h0100_0000;

    // Signed sample times zero-extended gain needs one extra bit.
    function automatic int fm_prod_width(input int sample_width, input int gain_width);
        return sample_width + gain_width + 1;
    endfunction

    function automatic int fm_ramp_len(input int interp_log2);
        return 1 << interp_log2;
    endfunction

endpackage

// File: rtl/fm_lin_interp.sv
// Linear interpolator: walks current toward target in 2^INTERP_LOG2 steps and
// snaps exactly onto target on the last step.
module fm_lin_interp
    import fm_mod_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int INTERP_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   run,
    input  logic [PHASE_WIDTH-1:0] target,
    output logic [PHASE_WIDTH-1:0] current,
    output logic                   cnt_zero
);

    localparam int RAMP_LEN = fm_ramp_len(INTERP_LOG2);
    localparam logic [INTERP_LOG2-1:0] CNT_LAST = INTERP_LOG2'(RAMP_LEN - 1);

    logic [PHASE_WIDTH-1:0]   current_r;
    logic [PHASE_WIDTH-1:0]   step_r;
    logic [INTERP_LOG2-1:0]   cnt_r;
    logic signed [PHASE_WIDTH:0] diff_s;
    logic signed [PHASE_WIDTH:0] step_full_s;

    // Difference in one extra bit so the sign survives any target/current pair.
    always_comb begin
        diff_s      = $signed({target[PHASE_WIDTH-1], target})
                    - $signed({current_r[PHASE_WIDTH-1], current_r});
        step_full_s = diff_s >>> INTERP_LOG2;
    end

    // Ramp state: clear has priority, then load of a new step, then stepping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            current_r <= {PHASE_WIDTH{1'b0}};
            step_r    <= {PHASE_WIDTH{1'b0}};
            cnt_r     <= {INTERP_LOG2{1'b0}};
        end else if (clear) begin
            current_r <= {PHASE_WIDTH{1'b0}};
            step_r    <= {PHASE_WIDTH{1'b0}};
            cnt_r     <= {INTERP_LOG2{1'b0}};
        end else if (load) begin
            step_r <= step_full_s[PHASE_WIDTH-1:0];
            cnt_r  <= CNT_LAST;
        end else if (run) begin
            if (cnt_r != {INTERP_LOG2{1'b0}}) begin
                current_r <= current_r + step_r;
                cnt_r     <= cnt_r - {{(INTERP_LOG2-1){1'b0}}, 1'b1};
            end else begin
                // Landing exactly on target discards the shift truncation error.
                current_r <= target;
            end
        end else begin
            current_r <= current_r;
        end
    end

    assign current  = current_r;
    assign cnt_zero = (cnt_r == {INTERP_LOG2{1'b0}});

endmodule

// File: rtl/fm_phase_inc_gen.sv
// FM front end: gain-scales audio samples into a ramped NCO frequency word.
// Define FM_DEV_CLAMP_EN to bound the deviation to +/-MAX_DEV.
module fm_phase_inc_gen
    import fm_mod_pkg::*;
#(
    parameter int PHASE_WIDTH  = 32,
    parameter int SAMPLE_WIDTH = 12,
    parameter int GAIN_WIDTH   = 16,
    parameter int INTERP_LOG2  = 4,
    parameter logic [PHASE_WIDTH-1:0] CARRIER_FCW = PHASE_WIDTH'(FM_DEF_CARRIER_FCW),
    parameter logic [PHASE_WIDTH-1:0] MAX_DEV     = PHASE_WIDTH'(FM_DEF_MAX_DEV)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [GAIN_WIDTH-1:0]   dev_gain,
    input  logic [SAMPLE_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [PHASE_WIDTH-1:0]  phi_inc_o,
    output logic                    inc_valid,
    output logic                    underrun
);

    localparam int PROD_W = fm_prod_width(SAMPLE_WIDTH, GAIN_WIDTH);

    fm_state_t state_r, state_nxt_s;
    logic [PHASE_WIDTH-1:0] target_r;
    logic                   started_r;
    logic                   underrun_r;
    logic [PHASE_WIDTH-1:0] phi_r;
    logic                   inc_valid_r;

    logic                   ready_s;
    logic                   capture_s;
    logic                   starve_s;
    logic signed [PROD_W-1:0]      sample_ext_s;
    logic signed [PROD_W-1:0]      gain_ext_s;
    logic signed [PROD_W-1:0]      prod_s;
    logic signed [PHASE_WIDTH-1:0] prod_ext_s;
    logic [PHASE_WIDTH-1:0]        target_nxt_s;
    logic [PHASE_WIDTH-1:0]        current_s;
    logic                          cnt_zero_s;
    logic                          clear_s;
    logic                          load_s;
    logic                          run_s;

    // Gain multiply and optional deviation clamp of the new target.
    always_comb begin
        sample_ext_s = PROD_W'($signed(s_data));
        gain_ext_s   = $signed(PROD_W'({1'b0, dev_gain}));
        prod_s       = sample_ext_s * gain_ext_s;
        prod_ext_s   = PHASE_WIDTH'(prod_s);
`ifdef FM_DEV_CLAMP_EN
        if (prod_ext_s > $signed(MAX_DEV)) begin
            target_nxt_s = MAX_DEV;
        end else if (prod_ext_s < -$signed(MAX_DEV)) begin
            target_nxt_s = -MAX_DEV;
        end else begin
            target_nxt_s = prod_ext_s;
        end
`else
        target_nxt_s = prod_ext_s;
`endif
    end

    // Next-state and handshake decode; enable low overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = 1'b0;
        capture_s   = 1'b0;
        starve_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                ready_s = 1'b1;
                if (s_valid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            LOAD: begin
                state_nxt_s = RAMP;
            end
            RAMP: begin
                if (cnt_zero_s) begin
                    ready_s = 1'b1;
                    if (s_valid) begin
                        capture_s   = 1'b1;
                        state_nxt_s = LOAD;
                    end else begin
                        starve_s    = 1'b1;
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = RAMP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (!enable) begin
            state_nxt_s = IDLE;
            capture_s   = 1'b0;
            starve_s    = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    assign clear_s = (state_nxt_s == IDLE);
    assign load_s  = (state_r == LOAD);
    assign run_s   = (state_r == RAMP);

    // Control registers: FSM state, captured target, stream flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            target_r   <= {PHASE_WIDTH{1'b0}};
            started_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                target_r <= target_nxt_s;
            end else begin
                target_r <= target_r;
            end
            if (clear_s) begin
                started_r  <= 1'b0;
                underrun_r <= 1'b0;
            end else begin
                started_r  <= started_r | capture_s;
                underrun_r <= underrun_r | (starve_s & started_r);
            end
        end
    end

    // Output register: frequency word wraps modulo 2^PHASE_WIDTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phi_r       <= CARRIER_FCW;
            inc_valid_r <= 1'b0;
        end else begin
            phi_r       <= CARRIER_FCW + current_s;
            inc_valid_r <= (state_r != IDLE);
        end
    end

    fm_lin_interp #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .INTERP_LOG2 (INTERP_LOG2)
    ) u_interp (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear_s),
        .load     (load_s),
        .run      (run_s),
        .target   (target_r),
        .current  (current_s),
        .cnt_zero (cnt_zero_s)
    );

    assign s_ready   = ready_s;
    assign phi_inc_o = phi_r;
    assign inc_valid = inc_valid_r;
    assign underrun  = underrun_r;

endmodule

// File: tb/tb_fm_phase_inc_gen.sv
// Scoreboard bench for fm_phase_inc_gen: handshakes push expected ramps, a
// negedge monitor compares phi_inc_o every clock against an arithmetic model.
module tb_fm_phase_inc_gen;

    localparam logic [31:0] C_FCW  = 32'h0400_0000;
    localparam longint      C_L    = 64'h0000_0000_0400_0000;
    localparam longint      MAXD_L = 64'h0000_0000_0100_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] dev_gain;
    logic [11:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] phi_inc_o;
    logic        inc_valid;
    logic        underrun;

    fm_phase_inc_gen dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .dev_gain  (dev_gain),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .phi_inc_o (phi_inc_o),
        .inc_valid (inc_valid),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     e0;
        longint old_v;
        longint tgt;
    } tr_t;

    tr_t         q[$];
    int          n_err = 0;
    int          n_chk = 0;
    bit          chk_en = 1'b0;
    logic [31:0] hold_exp = 32'h0400_0000;
    longint      model_cur = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic longint ref_target(input int d, input int g);
        longint p;
        p = longint'(d) * longint'(g);
`ifdef FM_DEV_CLAMP_EN
        if (p > MAXD_L) p = MAXD_L;
        if (p < -MAXD_L) p = -MAXD_L;
`endif
        return p;
    endfunction

    // Monitor: ramp starts 3 edges after handshake, lands on target 18 edges after.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        int          d;
        longint      st;
        if (chk_en) begin
            e = hold_exp;
            if (q.size() > 0) begin
                d  = cyc - q[0].e0;
                st = (q[0].tgt - q[0].old_v) >>> 4;
                if (d >= 3 && d <= 17) begin
                    e = 32'(C_L + q[0].old_v + longint'(d - 2) * st);
                end else if (d >= 18) begin
                    e = 32'(C_L + q[0].tgt);
                    hold_exp = e;
                    void'(q.pop_front());
                end
            end
            check("phi_inc_o", phi_inc_o, e);
            check("inc_valid", {31'b0, inc_valid}, 32'd1);
        end
    end

    task automatic send(input int d, input int g, output int e0);
        tr_t t;
        s_data   = 12'(d);
        dev_gain = 16'(g);
        s_valid  = 1'b1;
        e0       = -1;
        for (int i = 0; i < 200; i++) begin
            if (s_ready) begin
                t.e0      = cyc + 1;
                t.old_v   = model_cur;
                t.tgt     = ref_target(d, g);
                model_cur = t.tgt;
                q.push_back(t);
                e0 = t.e0;
                @(negedge clk);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_chk++;
        n_err++;
        $display("FAIL send_timeout: got no s_ready, expected s_ready within 200 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) return;
            @(negedge clk);
        end
        n_chk++;
        n_err++;
        $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int e0;
        int prev_e0;
        int dv;
        int gv;
        reset_n  = 1'b1;
        enable   = 1'b0;
        s_valid  = 1'b0;
        s_data   = 12'd0;
        dev_gain = 16'd0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_phi", phi_inc_o, C_FCW);
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_inc_valid", {31'b0, inc_valid}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_s_ready", {31'b0, s_ready}, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("en_s_ready", {31'b0, s_ready}, 32'd1);
        @(posedge clk);
        #1;
        hold_exp = C_FCW;
        chk_en   = 1'b1;

        // Basic ramp then starvation.
        @(negedge clk);
        send(100, 256, e0);
        repeat (3) @(negedge clk);
        check("first_step", phi_inc_o, 32'h0400_0640);
        wait_idle();
        check("ramp_final", phi_inc_o, 32'h0400_6400);
        check("underrun_set", {31'b0, underrun}, 32'd1);
        check("starve_s_ready", {31'b0, s_ready}, 32'd1);
        repeat (4) @(negedge clk);
        check("hold_final", phi_inc_o, 32'h0400_6400);

        // Extreme negative product: wraps or clamps.
        send(-2048, 65535, e0);
        wait_idle();
`ifdef FM_DEV_CLAMP_EN
        check("wrap_clamp", phi_inc_o, 32'h0300_0000);
`else
        check("wrap_clamp", phi_inc_o, 32'hFC00_0800);
`endif

        // Abort mid-ramp.
        send(500, 1000, e0);
        for (int i = 0; i < 40 && cyc < e0 + 6; i++) @(negedge clk);
        enable = 1'b0;
        chk_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_phi", phi_inc_o, C_FCW);
        check("abort_inc_valid", {31'b0, inc_valid}, 32'd0);
        check("abort_underrun", {31'b0, underrun}, 32'd0);
        s_data  = 12'd77;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("abort_no_ready", {31'b0, s_ready}, 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        q.delete();
        model_cur = 0;
        hold_exp  = C_FCW;
        enable    = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Back-to-back stream with s_valid held high.
        @(negedge clk);
        prev_e0 = 0;
        for (int i = 0; i < 6; i++) begin
            send((i % 2 == 0) ? 1000 : -1000, 300, e0);
            if (i > 0) check("b2b_spacing", 32'(e0 - prev_e0), 32'd17);
            check("b2b_underrun", {31'b0, underrun}, 32'd0);
            prev_e0 = e0;
        end
        wait_idle();

        // Randomized samples, gains and gaps.
        for (int i = 0; i < 30; i++) begin
            dv = int'($urandom_range(0, 4095)) - 2048;
            gv = int'($urandom_range(0, 65535));
            if (i == 3) gv = 65535;
            if (i == 4) dv = 2047;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(dv, gv, e0);
        end
        wait_idle();

        // Asynchronous reset mid-ramp.
        send(700, 900, e0);
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_phi", phi_inc_o, C_FCW);
        check("async_rst_inc_valid", {31'b0, inc_valid}, 32'd0);
        check("async_rst_s_ready", {31'b0, s_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
